corner_nms: RTL and testbench

- Downstream consumer of the Harris response stream.
- Takes one signed score per pixel in raster order, applies a threshold and 3x3 non-maximum suppression, and emits surviving corners as (x, y, score) records.
- Records go out through a small first-word-fall-through output queue with a valid/ready handshake.
- Sits between the score stage and the frame-level corner collector or display logic.

---
 rtl/corner_pkg.sv | 17 +
 rtl/corner_nms_if.sv | 33 +++
 rtl/corner_fifo.sv | 59 +++++
 rtl/corner_nms.sv | 160 ++++++++++++++++
 tb/tb_corner_nms.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/corner_pkg.sv
// Shared types and defaults for the corner detection back end.
package corner_pkg;

  localparam int unsigned DEF_IMG_W   = 64;
  localparam int unsigned DEF_IMG_H   = 64;
  localparam int unsigned DEF_SCORE_W = 32;
  localparam int unsigned DEF_XW      = $clog2(DEF_IMG_W);
  localparam int unsigned DEF_YW      = $clog2(DEF_IMG_H);

  // Corner record at default geometry; the collector consumes the same layout.
  typedef struct packed {
    logic        [DEF_XW-1:0]      x;
    logic        [DEF_YW-1:0]      y;
    logic signed [DEF_SCORE_W-1:0] score;
  } corner_rec_t;

endpackage

// File: rtl/corner_nms_if.sv
// Score input stream and corner record output handshake of corner_nms.
interface corner_nms_if
  import corner_pkg::*;
#(
  parameter int unsigned SCORE_W = DEF_SCORE_W,
  parameter int unsigned XW      = DEF_XW,
  parameter int unsigned YW      = DEF_YW
);

  logic signed [SCORE_W-1:0] score;
  logic                      score_valid;
  logic signed [SCORE_W-1:0] thresh;
  logic                      corner_valid;
  logic                      corner_ready;
  logic        [XW-1:0]      corner_x;
  logic        [YW-1:0]      corner_y;
  logic signed [SCORE_W-1:0] corner_score;
  logic                      frame_done;
  logic                      overflow;

  // Upstream score source plus downstream record consumer.
  modport master (
    output score, score_valid, thresh, corner_ready,
    input  corner_valid, corner_x, corner_y, corner_score, frame_done, overflow
  );

  // The NMS block itself.
  modport slave (
    input  score, score_valid, thresh, corner_ready,
    output corner_valid, corner_x, corner_y, corner_score, frame_done, overflow
  );

endinterface

// File: rtl/corner_fifo.sv
// First-word-fall-through queue of corner records with push/pop in one cycle.
module corner_fifo
  import corner_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type         rec_t = corner_rec_t
) (
  input  logic clk,
  input  logic reset,
  input  logic i_push,
  input  rec_t i_data,
  input  logic i_pop,
  output rec_t o_head,
  output logic o_empty,
  output logic o_drop
);

  localparam int unsigned PW = $clog2(DEPTH);

  rec_t          r_mem [DEPTH];
  logic [PW:0]   r_wptr;
  logic [PW:0]   r_rptr;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_wr;

  // Extra pointer bit distinguishes full from empty when the low bits match.
  always_comb begin
    w_empty = (r_wptr == r_rptr);
    w_full  = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
    w_pop   = i_pop & ~w_empty;
    // A pop in the same cycle frees the slot the push lands in.
    w_wr    = i_push & (~w_full | w_pop);
  end

  // Storage and pointer update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem  <= '{default: '0};
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wptr[PW-1:0]] <= i_data;
        r_wptr                <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
    end
  end

  assign o_head  = r_mem[r_rptr[PW-1:0]];
  assign o_empty = w_empty;
  assign o_drop  = i_push & w_full & ~w_pop;

endmodule

// File: rtl/corner_nms.sv
// Threshold plus 3x3 non-maximum suppression over a raster score stream;
// surviving corners leave as (x, y, score) records through a small queue.
module corner_nms
  import corner_pkg::*;
#(
  parameter int unsigned IMG_W      = DEF_IMG_W,
  parameter int unsigned IMG_H      = DEF_IMG_H,
  parameter int unsigned SCORE_W    = DEF_SCORE_W,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned XW         = $clog2(IMG_W),
  parameter int unsigned YW         = $clog2(IMG_H)
) (
  input logic         clk,
  input logic         reset,
  corner_nms_if.slave bus
);

  typedef logic signed [SCORE_W-1:0] score_t;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    score_t        score;
  } rec_t;

  // Raster position of the incoming score.
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;

  // r_lb_a holds row y-1, r_lb_b holds row y-2.
  score_t r_lb_a [IMG_W];
  score_t r_lb_b [IMG_W];

  // r_win[row][col]: row 0 oldest (y-2), col 0 oldest (x-2).
  score_t r_win [3][3];

  // Centre evaluation is pending on the window captured at the last accept.
  logic          r_eval;
  logic [XW-1:0] r_cx;
  logic [YW-1:0] r_cy;
  logic          r_frame_done;
  logic          r_overflow;

  score_t w_col_top;
  score_t w_col_mid;
  logic   w_last_x;
  logic   w_last_y;
  logic   w_interior;
  score_t w_c;
  logic   w_corner;
  rec_t   w_rec;
  rec_t   w_head;
  logic   w_empty;
  logic   w_drop;
  logic   w_pop;

  assign w_col_top = r_lb_b[r_x];
  assign w_col_mid = r_lb_a[r_x];
  assign w_last_x  = (r_x == XW'(IMG_W - 1));
  assign w_last_y  = (r_y == YW'(IMG_H - 1));
  // Centre is (x-1, y-1); x,y >= 2 keeps it off the left/top border and keeps
  // all three window columns on the same row set. x,y never exceed W-1/H-1,
  // so the right/bottom border is excluded for free.
  assign w_interior = (r_x >= XW'(2)) && (r_y >= YW'(2));

  // Line buffers carry no reset; stale contents are masked by the border test.
  always_ff @(posedge clk) begin
    if (bus.score_valid) begin
      r_lb_b[r_x] <= r_lb_a[r_x];
      r_lb_a[r_x] <= bus.score;
    end
  end

  // Shift the 3x3 window left by one column on each accepted score.
  always_ff @(posedge clk) begin
    if (bus.score_valid) begin
      for (int r = 0; r < 3; r++) begin
        r_win[r][0] <= r_win[r][1];
        r_win[r][1] <= r_win[r][2];
      end
      r_win[0][2] <= w_col_top;
      r_win[1][2] <= w_col_mid;
      r_win[2][2] <= bus.score;
    end
  end

  // Raster counters, evaluation strobe and frame-end pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x          <= '0;
      r_y          <= '0;
      r_eval       <= 1'b0;
      r_cx         <= '0;
      r_cy         <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_eval       <= bus.score_valid & w_interior;
      r_frame_done <= bus.score_valid & w_last_x & w_last_y;
      if (bus.score_valid) begin
        r_cx <= r_x - 1'b1;
        r_cy <= r_y - 1'b1;
        if (w_last_x) begin
          r_x <= '0;
          r_y <= w_last_y ? '0 : r_y + 1'b1;
        end else begin
          r_x <= r_x + 1'b1;
        end
      end
    end
  end

  // Corner test on the registered window. Ties resolve to the last pixel of a
  // plateau in raster order: >= against earlier neighbours, > against later.
  always_comb begin
    w_c      = r_win[1][1];
    w_corner = r_eval
             && (w_c >  bus.thresh)
             && (w_c >= r_win[0][0]) && (w_c >= r_win[0][1])
             && (w_c >= r_win[0][2]) && (w_c >= r_win[1][0])
             && (w_c >  r_win[1][2]) && (w_c >  r_win[2][0])
             && (w_c >  r_win[2][1]) && (w_c >  r_win[2][2]);
    w_rec       = '0;
    w_rec.x     = r_cx;
    w_rec.y     = r_cy;
    w_rec.score = w_c;
  end

  assign w_pop = ~w_empty & bus.corner_ready;

  corner_fifo #(
    .DEPTH (FIFO_DEPTH),
    .rec_t (rec_t)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_corner),
    .i_data  (w_rec),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_empty (w_empty),
    .o_drop  (w_drop)
  );

  // Sticky drop indicator.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end

  assign bus.corner_valid = ~w_empty;
  assign bus.corner_x     = w_head.x;
  assign bus.corner_y     = w_head.y;
  assign bus.corner_score = w_head.score;
  assign bus.frame_done   = r_frame_done;
  assign bus.overflow     = r_overflow;

endmodule

// File: tb/tb_corner_nms.sv
// Directed bench for corner_nms on an 8x8 frame.
module tb_corner_nms;

  localparam int W = 8;
  localparam int H = 8;

  typedef struct {
    int x;
    int y;
    int s;
  } rec_t;

  logic clk;
  logic reset;
  int   n_assert;
  int   n_fail;
  int   fd_cnt;
  int   fd0;
  int   img [W*H];
  rec_t got [$];

  corner_nms_if #(.SCORE_W(32), .XW(3), .YW(3)) bus ();

  corner_nms #(
    .IMG_W      (W),
    .IMG_H      (H),
    .SCORE_W    (32),
    .FIFO_DEPTH (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Consumer side: a record is taken whenever valid and ready meet.
  always @(negedge clk) begin
    if (bus.corner_valid && bus.corner_ready) begin
      got.push_back('{int'(bus.corner_x), int'(bus.corner_y), int'(bus.corner_score)});
    end
    if (bus.frame_done) fd_cnt++;
  end

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_rec(input string tag, input int idx, input int x, input int y,
                           input int s);
    check({tag, "_x"}, (got.size() > idx) ? got[idx].x : -1, x);
    check({tag, "_y"}, (got.size() > idx) ? got[idx].y : -1, y);
    check({tag, "_s"}, (got.size() > idx) ? got[idx].s : -99999, s);
  endtask

  // Inputs change 2 time units after a rising edge, so the DUT samples them
  // at the next edge; the task returns just after that edge.
  task automatic drive(input logic v, input int s);
    bus.score_valid = v;
    bus.score       = s;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0);
  endtask

  task automatic fill(input int v);
    for (int i = 0; i < W*H; i++) img[i] = v;
  endtask

  task automatic send_frame;
    for (int i = 0; i < W*H; i++) drive(1'b1, img[i]);
    idle(2);
  endtask

  initial begin
    n_assert         = 0;
    n_fail           = 0;
    fd_cnt           = 0;
    reset            = 1'b1;
    bus.score        = 0;
    bus.score_valid  = 1'b0;
    bus.thresh       = 0;
    bus.corner_ready = 1'b0;

    // Reset state
    #3;
    check("rst_valid", bus.corner_valid, 0);
    check("rst_fd",    bus.frame_done, 0);
    check("rst_ovf",   bus.overflow, 0);
    check("rst_x",     bus.corner_x, 0);
    check("rst_y",     bus.corner_y, 0);
    check("rst_score", bus.corner_score, 0);
    @(posedge clk);
    #2;
    reset = 1'b0;

    // Single peak at (3,4): pushed on the edge after (4,5) = index 44 is taken
    fill(0);
    img[4*W+3] = 100;
    bus.thresh = 10;
    fd0 = fd_cnt;
    for (int i = 0; i < W*H; i++) begin
      drive(1'b1, img[i]);
      if (i == 44) check("pk_pre_valid", bus.corner_valid, 0);
      if (i == 45) begin
        check("pk_valid", bus.corner_valid, 1);
        check("pk_x",     bus.corner_x, 3);
        check("pk_y",     bus.corner_y, 4);
        check("pk_score", bus.corner_score, 100);
      end
      if (i == 62) check("fd_early", bus.frame_done, 0);
      if (i == 63) check("fd_pulse", bus.frame_done, 1);
    end
    drive(1'b0, 0);
    check("fd_low", bus.frame_done, 0);
    drive(1'b0, 0);
    check("fd_count", fd_cnt - fd0, 1);
    got.delete();
    bus.corner_ready = 1'b1;
    idle(2);
    check("pk_n", got.size(), 1);
    check_rec("pk_rec", 0, 3, 4, 100);
    check("pk_drained", bus.corner_valid, 0);

    // Threshold is strict: a score equal to it is not a corner
    got.delete();
    bus.thresh = 100;
    send_frame();
    check("thr_n", got.size(), 0);

    // Two-pixel plateau: only the later pixel (4,3) survives
    got.delete();
    fill(0);
    img[3*W+3] = 50;
    img[3*W+4] = 50;
    bus.thresh = 0;
    send_frame();
    check("plat_n", got.size(), 1);
    check_rec("plat_rec", 0, 4, 3, 50);

    // Border peaks are never reported
    got.delete();
    fill(0);
    img[2*W+0] = 500;
    img[7*W+7] = 500;
    send_frame();
    check("border_n", got.size(), 0);

    // All-negative frame with one local maximum
    got.delete();
    fill(-500);
    img[2*W+5] = -100;
    bus.thresh = -1000;
    send_frame();
    check("neg_n", got.size(), 1);
    check_rec("neg_rec", 0, 5, 2, -100);

    // Six isolated peaks into a 4-deep queue with no consumer
    got.delete();
    bus.corner_ready = 1'b0;
    fill(0);
    img[1*W+2] = 201;
    img[1*W+5] = 202;
    img[3*W+2] = 203;
    img[3*W+5] = 204;
    img[5*W+2] = 205;
    img[5*W+5] = 206;
    bus.thresh = 10;
    send_frame();
    check("ovf_flag",  bus.overflow, 1);
    check("ovf_valid", bus.corner_valid, 1);
    check("ovf_head",  bus.corner_score, 201);
    bus.corner_ready = 1'b1;
    idle(6);
    check("ovf_n", got.size(), 4);
    check_rec("ovf_r0", 0, 2, 1, 201);
    check_rec("ovf_r1", 1, 5, 1, 202);
    check_rec("ovf_r2", 2, 2, 3, 203);
    check_rec("ovf_r3", 3, 5, 3, 204);
    check("ovf_drained", bus.corner_valid, 0);
    check("ovf_sticky",  bus.overflow, 1);

    // Reset mid-frame with a queued corner, then a fresh frame
    got.delete();
    bus.corner_ready = 1'b0;
    fill(0);
    img[1*W+2] = 300;
    for (int i = 0; i < 21; i++) drive(1'b1, img[i]);
    check("mid_valid", bus.corner_valid, 1);
    bus.score_valid = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    check("mid_rst_valid", bus.corner_valid, 0);
    check("mid_rst_ovf",   bus.overflow, 0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    bus.corner_ready = 1'b1;
    fill(0);
    img[2*W+3] = 77;
    send_frame();
    check("post_n", got.size(), 1);
    check_rec("post_rec", 0, 3, 2, 77);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Hard stop in case the sequence above stalls.
  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish before time limit");
    $fatal(1);
  end

endmodule
